sqw_input_conditioner: RTL

- Front-end stage feeding the SquareWave state classifier.
- Takes the raw asynchronous square-wave pin and synchronises and deglitches it.
- Produces a clean level, single-cycle edge pulses and a measured half-period, all in system-clock ticks.
- Lets the downstream classifier work on the clean wave and the integer period alone, never on raw pin timing.

---
 rtl/sqw_pkg.sv | 16 +
 rtl/sqw_glitch_filter.sv | 80 ++++++++
 rtl/sqw_input_conditioner.sv | 97 +++++++++
 3 files changed

// File: rtl/sqw_pkg.sv
// rtl/sqw_pkg.sv - shared types and defaults for the square-wave input conditioner
// Purpose: FSM state encoding and default sizing used by sqw_input_conditioner
//          and sqw_glitch_filter.
// Contents: sqw_state_e (WAIT_EDGE, MEASURE), SQW_FILT_LEN, SQW_CNT_W, SQW_GLITCH_W.
package sqw_pkg;

  typedef enum logic [0:0] {
    WAIT_EDGE = 1'b0,
    MEASURE   = 1'b1
  } sqw_state_e;

  localparam int SQW_FILT_LEN = 4;
  localparam int SQW_CNT_W    = 17;
  localparam int SQW_GLITCH_W = 8;

endpackage

// File: rtl/sqw_glitch_filter.sv
// rtl/sqw_glitch_filter.sv - synchroniser, run-length deglitcher and edge pulse generator
// Purpose: bring the raw pin into iClk, accept a level change only after FILT_LEN
//          consecutive differing samples, and flag each accepted change.
// Ports:
//   iClk, iRst_n  clock, asynchronous active-low reset
//   iRaw          raw asynchronous square-wave pin
//   oWave         clean level
//   oRise/oFall   one-cycle pulses coincident with the new oWave value
//   oGlitchCnt    saturating count of rejected glitches
// Build option: define SQW_GLITCH_CNT_EN to generate the glitch counter;
//               otherwise oGlitchCnt is tied to zero.
module sqw_glitch_filter
  import sqw_pkg::*;
#(
  parameter int FILT_LEN = SQW_FILT_LEN
) (
  input  logic                    iClk,
  input  logic                    iRst_n,
  input  logic                    iRaw,
  output logic                    oWave,
  output logic                    oRise,
  output logic                    oFall,
  output logic [SQW_GLITCH_W-1:0] oGlitchCnt
);

  // Run counter tops out at FILT_LEN-1: the sample that would make it FILT_LEN
  // toggles the level instead, so FILT_LEN=1 toggles on the first differing sample.
  localparam logic [3:0] RUN_LAST = 4'(FILT_LEN - 1);

  logic       s1;
  logic       s2;
  logic [3:0] runCnt;
  logic       differ;
  logic       toggle;
  logic       glitch;

  assign differ = (s2 != oWave);
  assign toggle = differ && (runCnt == RUN_LAST);
  // A partial run that collapses back to the current level is a rejected glitch.
  assign glitch = !differ && (runCnt != 4'd0);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      runCnt <= 4'd0;
      oWave  <= 1'b0;
      oRise  <= 1'b0;
      oFall  <= 1'b0;
    end else begin
      s1    <= iRaw;
      s2    <= s1;
      oRise <= toggle && !oWave;
      oFall <= toggle && oWave;
      if (toggle) begin
        oWave  <= ~oWave;
        runCnt <= 4'd0;
      end else if (differ) begin
        runCnt <= runCnt + 4'd1;
      end else begin
        runCnt <= 4'd0;
      end
    end
  end

`ifdef SQW_GLITCH_CNT_EN
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oGlitchCnt <= '0;
    end else if (glitch && (oGlitchCnt != {SQW_GLITCH_W{1'b1}})) begin
      oGlitchCnt <= oGlitchCnt + SQW_GLITCH_W'(1);
    end
  end
`else
  logic unusedGlitch;
  assign unusedGlitch = glitch;
  assign oGlitchCnt   = '0;
`endif

endmodule

// File: rtl/sqw_input_conditioner.sv
// rtl/sqw_input_conditioner.sv - square-wave front end: clean level, edges and half-period
// Purpose: deglitch the raw square wave and measure the tick count between clean edges.
// Ports:
//   iClk, iRst_n  system clock, asynchronous active-low reset
//   isquareWave   raw square-wave pin (asynchronous)
//   oWave         filtered level; oRise/oFall one-cycle clean edge pulses
//   oHalfPeriod   ticks between the last two clean edges, held until next update
//   oValid        one-cycle strobe when oHalfPeriod/oLevel update
//   oLevel        level of the half-period just measured
//   oTimeout      set when a measurement saturates without an edge
//   oGlitchCnt    rejected-glitch count (live only with SQW_GLITCH_CNT_EN defined)
module sqw_input_conditioner
  import sqw_pkg::*;
#(
  parameter int FILT_LEN = SQW_FILT_LEN,
  parameter int CNT_W    = SQW_CNT_W
) (
  input  logic                    iClk,
  input  logic                    iRst_n,
  input  logic                    isquareWave,
  output logic                    oWave,
  output logic                    oRise,
  output logic                    oFall,
  output logic [CNT_W-1:0]        oHalfPeriod,
  output logic                    oValid,
  output logic                    oLevel,
  output logic                    oTimeout,
  output logic [SQW_GLITCH_W-1:0] oGlitchCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  sqw_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             edgeHit;
  logic             cntSat;

  sqw_glitch_filter #(
    .FILT_LEN (FILT_LEN)
  ) uFilter (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .iRaw       (isquareWave),
    .oWave      (oWave),
    .oRise      (oRise),
    .oFall      (oFall),
    .oGlitchCnt (oGlitchCnt)
  );

  assign edgeHit = oRise || oFall;
  assign cntSat  = (cnt == CNT_MAX);

  // cnt is 1 on the cycle after an edge, so it equals the edge spacing on the next edge.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt <= '0;
    end else if (edgeHit) begin
      cnt <= CNT_W'(1);
    end else if (!cntSat) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state       <= WAIT_EDGE;
      oHalfPeriod <= '0;
      oLevel      <= 1'b0;
      oValid      <= 1'b0;
      oTimeout    <= 1'b0;
    end else begin
      oValid <= 1'b0;
      case (state)
        WAIT_EDGE: begin
          // Start time of this edge is unknown, so it only arms the measurement.
          if (edgeHit) begin
            state    <= MEASURE;
            oTimeout <= 1'b0;
          end
        end
        MEASURE: begin
          // An edge on the saturation cycle is still a valid full-scale period.
          if (edgeHit) begin
            oHalfPeriod <= cnt;
            oLevel      <= ~oWave;
            oValid      <= 1'b1;
          end else if (cntSat) begin
            state    <= WAIT_EDGE;
            oTimeout <= 1'b1;
          end
        end
        default: state <= WAIT_EDGE;
      endcase
    end
  end

endmodule
